// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg
// Purpose: CPU-wide sizing parameters shared by the execution units.
// Contents: RSZ, the architectural register width in bits.
package cpu_params_pkg;

    localparam int RSZ = 32;

endpackage : cpu_params_pkg

// File: rtl/cpu_structs_pkg.sv
// cpu_structs_pkg
// Purpose: shared operation encodings for the CPU execution units.
// Contents: IDR_OP_TYPE, the divide/remainder opcode, and a helper that
//           reports whether an opcode treats its operands as signed.
package cpu_structs_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } IDR_OP_TYPE;

    // Quotient and remainder are always both produced; the opcode only
    // selects whether the operands are two's-complement or unsigned.
    function automatic logic idr_is_signed(input IDR_OP_TYPE op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage : cpu_structs_pkg

// File: rtl/idrfu_intf.sv
// IDRFU_intf
// Purpose: request/response bundle between the issue logic and the
//          integer divide/remainder functional unit.
// Signals: Rs1_data (dividend), Rs2_data (divisor), op, start  -> unit
//          quotient, remainder, done                          <- unit
// Modports: slave (the divider), master (the requester).
interface IDRFU_intf;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    logic [RSZ-1:0] Rs1_data;
    logic [RSZ-1:0] Rs2_data;
    IDR_OP_TYPE     op;
    logic           start;
    logic [RSZ-1:0] quotient;
    logic [RSZ-1:0] remainder;
    logic           done;

    modport slave (
        input  Rs1_data, Rs2_data, op, start,
        output quotient, remainder, done
    );

    modport master (
        output Rs1_data, Rs2_data, op, start,
        input  quotient, remainder, done
    );

endinterface : IDRFU_intf

// File: rtl/int_div_rem.sv
// int_div_rem
// Purpose: multi-cycle integer divide/remainder unit (DIV, DIVU, REM, REMU).
//          Restoring division, one quotient bit per cycle, on operand
//          magnitudes; signs are reapplied in a single fix-up cycle.
//          Divide-by-zero and signed overflow finish immediately.
// Ports:
//   clk_in     - clock, all state updates on its rising edge
//   reset_in   - synchronous active-high reset
//   idrfu_bus  - IDRFU_intf slave: Rs1_data, Rs2_data, op, start in;
//                quotient, remainder (registered), done (1-cycle pulse) out
module int_div_rem
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
(
    input  logic      clk_in,
    input  logic      reset_in,
    IDRFU_intf.slave  idrfu_bus
);

    localparam int CNT_W = $clog2(RSZ);
    localparam logic [RSZ-1:0] SIGN_MIN = {1'b1, {(RSZ-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    IDR_OP_TYPE      r_op;
    logic [RSZ-1:0]  r_quo;        // holds dividend magnitude, shifted out as quotient shifts in
    logic [RSZ-1:0]  r_rem;        // partial remainder, always < divisor magnitude
    logic [RSZ-1:0]  r_dvs;        // divisor magnitude
    logic            r_neg_q;
    logic            r_neg_r;
    logic [RSZ-1:0]  r_quotient;
    logic [RSZ-1:0]  r_remainder;
    logic            r_done;

    // Operand conditioning at latch time.
    logic            w_signed;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [RSZ-1:0]  w_dvd_mag;
    logic [RSZ-1:0]  w_dvs_mag;
    logic            w_div_zero;
    logic            w_overflow;

    assign w_signed   = idr_is_signed(idrfu_bus.op);
    assign w_dvd_neg  = w_signed && idrfu_bus.Rs1_data[RSZ-1];
    assign w_dvs_neg  = w_signed && idrfu_bus.Rs2_data[RSZ-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude; only the overflow pairing needs special handling.
    assign w_dvd_mag  = w_dvd_neg ? (~idrfu_bus.Rs1_data + 1'b1) : idrfu_bus.Rs1_data;
    assign w_dvs_mag  = w_dvs_neg ? (~idrfu_bus.Rs2_data + 1'b1) : idrfu_bus.Rs2_data;
    assign w_div_zero = (idrfu_bus.Rs2_data == '0);
    assign w_overflow = w_signed && (idrfu_bus.Rs1_data == SIGN_MIN) &&
                        (idrfu_bus.Rs2_data == '1);

    // One restoring step: shift the next dividend bit into the remainder and
    // trial-subtract. Because r_rem < r_dvs, a non-negative difference always
    // fits in RSZ bits and a negative one always sets the top bit.
    logic [RSZ:0]    w_shift;
    logic [RSZ:0]    w_trial;

    assign w_shift = {r_rem, r_quo[RSZ-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    // Sign fix-up of the magnitude results (signed ops only).
    logic            w_fix_signed;
    logic [RSZ-1:0]  w_q_fix;
    logic [RSZ-1:0]  w_r_fix;

    assign w_fix_signed = idr_is_signed(r_op);
    assign w_q_fix = (w_fix_signed && r_neg_q) ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = (w_fix_signed && r_neg_r) ? (~r_rem + 1'b1) : r_rem;

    // NOTE: every register here, including the datapath, is cleared on reset
    // so an aborted operation leaves no residue for the next request.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= DIV;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (idrfu_bus.start) begin
                        r_op    <= idrfu_bus.op;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_quo   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= idrfu_bus.Rs1_data;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_overflow) begin
                            r_quotient  <= SIGN_MIN;
                            r_remainder <= '0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_cnt   <= CNT_W'(RSZ - 1);
                            r_state <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (!w_trial[RSZ]) begin
                        r_rem <= w_trial[RSZ-1:0];
                        r_quo <= {r_quo[RSZ-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[RSZ-1:0];
                        r_quo <= {r_quo[RSZ-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end

                FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_done      <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign idrfu_bus.quotient  = r_quotient;
    assign idrfu_bus.remainder = r_remainder;
    assign idrfu_bus.done      = r_done;

endmodule : int_div_rem

// File: tb/tb_int_div_rem.sv
// tb_int_div_rem
// Directed bench for int_div_rem. Cycle numbering: the rising edge that
// samples start is edge 0; "cycle k" is the period ending at edge k, observed
// at the falling edge inside it. A normal op shows done in cycle 34, a
// special case in cycle 1.
module tb_int_div_rem;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    IDRFU_intf bus ();

    int_div_rem dut (
        .clk_in    (clk),
        .reset_in  (rst),
        .idrfu_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cyc;
    int pulses;

    // Issue one request for a single cycle, then scramble the inputs and
    // record when (and how often) done pulses within the budget.
    task automatic run_op(input IDR_OP_TYPE op, input logic [31:0] a,
                          input logic [31:0] b, input int budget);
        @(negedge clk);
        bus.op       = op;
        bus.Rs1_data = a;
        bus.Rs2_data = b;
        bus.start    = 1'b1;
        @(posedge clk);
        done_cyc = -1;
        pulses   = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start    = 1'b0;
                bus.op       = DIVU;
                bus.Rs1_data = 32'h1234_5678;
                bus.Rs2_data = 32'h0000_0001;
            end
            if (bus.done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.Rs1_data = 32'd50;
        bus.Rs2_data = 32'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", bus.done);
        end
        checks++;
        if (bus.quotient !== 32'h0) begin
            errors++; $display("FAIL reset_quotient: got %h expected 00000000", bus.quotient);
        end
        checks++;
        if (bus.remainder !== 32'h0) begin
            errors++; $display("FAIL reset_remainder: got %h expected 00000000", bus.remainder);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_unsigned();
        run_op(DIVU, 32'd100, 32'd7, 40);
        checks++;
        if (bus.quotient !== 32'd14) begin
            errors++; $display("FAIL divu_100_7_q: got %h expected %h", bus.quotient, 32'd14);
        end
        checks++;
        if (bus.remainder !== 32'd2) begin
            errors++; $display("FAIL divu_100_7_r: got %h expected %h", bus.remainder, 32'd2);
        end
        checks++;
        if (done_cyc !== 34) begin
            errors++; $display("FAIL divu_100_7_latency: got %0d expected 34", done_cyc);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL divu_100_7_pulses: got %0d expected 1", pulses);
        end

        run_op(DIVU, 32'hFFFF_FFF9, 32'd2, 40);
        checks++;
        if (bus.quotient !== 32'h7FFF_FFFC || bus.remainder !== 32'h1) begin
            errors++; $display("FAIL divu_big_2: got q=%h r=%h expected q=7ffffffc r=00000001",
                               bus.quotient, bus.remainder);
        end

        // Same bit patterns as the signed overflow case, but unsigned.
        run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        checks++;
        if (bus.quotient !== 32'h0 || bus.remainder !== 32'h8000_0000 || done_cyc !== 34) begin
            errors++; $display("FAIL divu_min_allones: got q=%h r=%h cyc=%0d expected q=00000000 r=80000000 cyc=34",
                               bus.quotient, bus.remainder, done_cyc);
        end
    endtask

    task automatic test_signed();
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 40);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2: got q=%h r=%h expected q=fffffffd r=ffffffff",
                               bus.quotient, bus.remainder);
        end
        checks++;
        if (done_cyc !== 34) begin
            errors++; $display("FAIL div_m7_2_latency: got %0d expected 34", done_cyc);
        end

        run_op(REM, 32'hFFFF_FFF9, 32'd2, 40);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rem_m7_2: got q=%h r=%h expected q=fffffffd r=ffffffff",
                               bus.quotient, bus.remainder);
        end

        // 7 / -2 -> -3 remainder 1 (remainder takes the dividend's sign).
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 40);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'h1) begin
            errors++; $display("FAIL div_7_m2: got q=%h r=%h expected q=fffffffd r=00000001",
                               bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero();
        run_op(REMU, 32'd5, 32'd0, 40);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5) begin
            errors++; $display("FAIL remu_5_0: got q=%h r=%h expected q=ffffffff r=00000005",
                               bus.quotient, bus.remainder);
        end
        checks++;
        if (done_cyc !== 1 || pulses !== 1) begin
            errors++; $display("FAIL remu_5_0_timing: got cyc=%0d pulses=%0d expected cyc=1 pulses=1",
                               done_cyc, pulses);
        end

        run_op(DIV, 32'hFFFF_FFF9, 32'd0, 40);
        checks++;
        if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'hFFFF_FFF9 || done_cyc !== 1) begin
            errors++; $display("FAIL div_m7_0: got q=%h r=%h cyc=%0d expected q=ffffffff r=fffffff9 cyc=1",
                               bus.quotient, bus.remainder, done_cyc);
        end
    endtask

    task automatic test_overflow();
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        checks++;
        if (bus.quotient !== 32'h8000_0000 || bus.remainder !== 32'h0) begin
            errors++; $display("FAIL div_ovf: got q=%h r=%h expected q=80000000 r=00000000",
                               bus.quotient, bus.remainder);
        end
        checks++;
        if (done_cyc !== 1 || pulses !== 1) begin
            errors++; $display("FAIL div_ovf_timing: got cyc=%0d pulses=%0d expected cyc=1 pulses=1",
                               done_cyc, pulses);
        end

        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        checks++;
        if (bus.quotient !== 32'h8000_0000 || bus.remainder !== 32'h0 || done_cyc !== 1) begin
            errors++; $display("FAIL rem_ovf: got q=%h r=%h cyc=%0d expected q=80000000 r=00000000 cyc=1",
                               bus.quotient, bus.remainder, done_cyc);
        end
    endtask

    // Abort mid-CALC: ignored start while busy, then reset with a coincident
    // start; nothing may complete, and a fresh op must run cleanly.
    task automatic test_abort();
        @(negedge clk);
        bus.op       = DIVU;
        bus.Rs1_data = 32'd1000;
        bus.Rs2_data = 32'd10;
        bus.start    = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            case (c)
                1:  bus.start = 1'b0;
                5:  begin bus.start = 1'b1; bus.Rs1_data = 32'd9; bus.Rs2_data = 32'd3; end
                6:  bus.start = 1'b0;
                10: begin rst = 1'b1; bus.start = 1'b1; end
                11: begin
                        rst = 1'b0;
                        bus.start = 1'b0;
                        checks++;
                        if (bus.quotient !== 32'h0 || bus.remainder !== 32'h0) begin
                            errors++; $display("FAIL abort_outputs: got q=%h r=%h expected q=00000000 r=00000000",
                                               bus.quotient, bus.remainder);
                        end
                    end
                default: ;
            endcase
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end

        run_op(DIVU, 32'd9, 32'd3, 40);
        checks++;
        if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0 || done_cyc !== 34) begin
            errors++; $display("FAIL after_abort_9_3: got q=%h r=%h cyc=%0d expected q=00000003 r=00000000 cyc=34",
                               bus.quotient, bus.remainder, done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        int second_cyc;
        logic [31:0] q_cap;
        logic [31:0] r_cap;
        first_cyc  = -1;
        second_cyc = -1;
        q_cap = 32'hDEAD_BEEF;
        r_cap = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.op       = DIVU;
        bus.Rs1_data = 32'hFFFF_FFFF;
        bus.Rs2_data = 32'd1;
        bus.start    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = c;
                    q_cap = bus.quotient;
                    r_cap = bus.remainder;
                end else if (second_cyc < 0) begin
                    second_cyc = c;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (q_cap !== 32'hFFFF_FFFF || r_cap !== 32'h0) begin
            errors++; $display("FAIL b2b_result: got q=%h r=%h expected q=ffffffff r=00000000", q_cap, r_cap);
        end
        checks++;
        if (first_cyc !== 34) begin
            errors++; $display("FAIL b2b_first_done: got %0d expected 34", first_cyc);
        end
        // Next op sampled at edge 35 (first IDLE cycle), done 34 cycles later.
        checks++;
        if (second_cyc !== 69) begin
            errors++; $display("FAIL b2b_second_done: got %0d expected 69", second_cyc);
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op       = DIV;
        bus.Rs1_data = '0;
        bus.Rs2_data = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_int_div_rem

// File: doc/int_div_rem.md
INT_DIV_REM -- requirements
Module: int_div_rem

Interface
REQ-001 Parameters: none; width RSZ (32) SHALL come from cpu_params_pkg.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_in  input  1  synchronous, active-high reset.
REQ-004 idrfu_bus.Rs1_data  input  RSZ  dividend.
REQ-005 idrfu_bus.Rs2_data  input  RSZ  divisor.
REQ-006 idrfu_bus.op  input  IDR_OP_TYPE  DIV / DIVU / REM / REMU; selects signedness.
REQ-007 idrfu_bus.start  input  1  request; sampled only in IDLE.
REQ-008 idrfu_bus.quotient  output  RSZ  registered quotient.
REQ-009 idrfu_bus.remainder  output  RSZ  registered remainder.
REQ-010 idrfu_bus.done  output  1  one-cycle result-valid pulse.
REQ-011 Ports 004-010 SHALL be connected through the IDRFU_intf slave modport.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-013 IDLE with start=1 at edge 0: latch Rs1_data, Rs2_data and op. Then take one of three paths:
- divisor == 0: go to DONE.
- signed overflow (op DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): go to DONE.
- otherwise: go to CALC with iteration counter = 31.
REQ-014 Signed ops: latched operands SHALL be converted to magnitudes at latch. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
REQ-015 CALC: one restoring iteration per cycle on a 33-bit partial remainder. Shift in the next dividend bit, trial-subtract the divisor magnitude, set the quotient bit when the result is non-negative. The counter SHALL decrement each cycle; counter == 0 goes to FIX. There are exactly 32 CALC cycles.
REQ-016 FIX (one cycle): two's-complement negate the quotient if neg_q and the remainder if neg_r (signed ops only). Write both to the outputs, then go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-018 Latency: normal ops SHALL assert done in cycle 34 (start sampled at cycle 0). Special cases SHALL assert done in cycle 1.
REQ-019 Divide by zero (all ops): quotient = 0xFFFFFFFF, remainder = dividend.
REQ-020 Signed overflow: quotient = 0x80000000, remainder = 0.
REQ-021 Both quotient and remainder SHALL be produced for every op. op affects signedness only.
REQ-022 start while not in IDLE SHALL be ignored. Operand changes after latch SHALL have no effect.
REQ-023 quotient/remainder SHALL hold their values from done until the next accepted start's FIX or DONE update.
REQ-024 start sampled in the same cycle IDLE is re-entered after DONE SHALL be accepted (back-to-back ops).

Reset
REQ-025 reset_in=1 SHALL force, at the next edge, in any state including mid-CALC:
- state = IDLE
- done = 0, quotient = 0, remainder = 0
- counter = 0, internal registers cleared
REQ-026 start coincident with reset_in=1 SHALL be ignored.
REQ-027 After reset deasserts, the first start SHALL behave per REQ-013 with no residue from an aborted operation.

Structure
REQ-028 RSZ SHALL be in cpu_params_pkg. IDR_OP_TYPE SHALL be in cpu_structs_pkg. The FSM state enum SHALL be local to the module.
REQ-029 Single module, no sub-modules. The 33-bit trial subtractor SHALL be inline. Target 150-250 RTL lines.

Verification
REQ-030 DIVU 100 / 7 -> quotient 14, remainder 2, done cycle 34, single pulse.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); REM same operands -> same outputs.
REQ-032 REMU 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, done cycle 1.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, done cycle 1.
REQ-034 Start DIVU 1000/10. At cycle 5, pulse start with 9/3. At cycle 10, assert reset_in for one cycle. Required: done never pulses, outputs 0 after reset. A new DIVU 9/3 afterwards returns quotient 3, remainder 0, done at cycle 34 after its start.
REQ-035 Back-to-back: start held high continuously with DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0. The next op starts in the cycle after done and its done follows 34 cycles later.
